// File: rtl/spike_rate_encoder_if.sv
// Handshake bundle between a frame source / spike consumer and the rate encoder.
// The encoder takes the slave view; the frame source and spike sink share the master view.
interface spike_rate_encoder_if #(
  parameter int N_CH    = 8,
  parameter int VAL_W   = 8,
  parameter int T_STEPS = 16
);
  localparam int SW = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [N_CH*VAL_W-1:0]   in_data;
  logic [N_CH-1:0]         spike_out;
  logic                    out_valid;
  logic                    out_ready;
  logic [SW-1:0]           step_idx;
  logic                    done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, spike_out, out_valid, step_idx, done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, spike_out, out_valid, step_idx, done
  );
endinterface

// File: rtl/spike_rate_encoder.sv
// Sigma-delta rate encoder: one accepted frame of intensities is replayed as T_STEPS spike vectors.
// Step 0 is presented the cycle after acceptance; steps hold under out_ready low; done pulses once at the end.
module spike_rate_encoder #(
  parameter int N_CH    = 8,
  parameter int VAL_W   = 8,
  parameter int T_STEPS = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  spike_rate_encoder_if.slave  bus
);
  localparam int SW = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(T_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                       state;
  logic [N_CH-1:0][VAL_W-1:0]   intens;
  logic [N_CH-1:0][VAL_W-1:0]   acc;
  logic [N_CH-1:0][VAL_W:0]     sum;
  logic [N_CH-1:0]              spike_q;
  logic [SW-1:0]                step_q;

  // One extra bit per channel: the carry out of the accumulator is the spike.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_CH; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, intens[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      intens  <= '0;
      acc     <= '0;
      spike_q <= '0;
      step_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            // Accumulator starts at 0+I, so step 0 can never carry.
            intens  <= bus.in_data;
            acc     <= bus.in_data;
            spike_q <= '0;
            step_q  <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.out_ready) begin
            if (step_q == LAST_STEP) begin
              spike_q <= '0;
              step_q  <= '0;
              state   <= S_DONE;
            end else begin
              for (int i = 0; i < N_CH; i++) begin
                acc[i]     <= sum[i][VAL_W-1:0];
                spike_q[i] <= sum[i][VAL_W];
              end
              step_q <= step_q + SW'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_RUN);
  assign bus.done      = (state == S_DONE);
  assign bus.spike_out = spike_q;
  assign bus.step_idx  = step_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Scoreboard bench for spike_rate_encoder: expected steps are queued at frame acceptance
// from a closed-form spike formula and popped on every consumed timestep.
module tb_spike_rate_encoder;
  localparam int N_CH    = 8;
  localparam int VAL_W   = 8;
  localparam int T_STEPS = 16;
  localparam int SW      = $clog2(T_STEPS);

  typedef struct packed {
    logic [SW-1:0]   step;
    logic [N_CH-1:0] spk;
  } exp_t;

  typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;

  logic clk;
  logic rstn;

  spike_rate_encoder_if #(.N_CH(N_CH), .VAL_W(VAL_W), .T_STEPS(T_STEPS)) bus ();

  spike_rate_encoder #(.N_CH(N_CH), .VAL_W(VAL_W), .T_STEPS(T_STEPS)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  exp_t    q[$];
  mstate_t m_state = M_IDLE;
  bit      m_ok    = 0;
  int      n_acc   = 0;
  int      n_done  = 0;
  int      last_acc = 0;
  int      prev_acc = 0;
  int      done_cyc = 0;
  int      cnt     [N_CH];
  int      exp_cnt [N_CH];
  bit      prev_stall = 0;
  logic [N_CH-1:0] hold_spk;
  logic [SW-1:0]   hold_step;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int intens_of(input logic [N_CH*VAL_W-1:0] d, input int ch);
    logic [VAL_W-1:0] v;
    v = d[ch*VAL_W +: VAL_W];
    return int'(v);
  endfunction

  // Monitor / scoreboard: samples on the falling edge, inputs are stable by then.
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      q.delete();
      m_state    = M_IDLE;
      m_ok       = 1;
      prev_stall = 0;
    end else if (m_ok) begin
      chk("in_ready",  32'(bus.in_ready),  32'(m_state == M_IDLE));
      chk("out_valid", 32'(bus.out_valid), 32'(m_state == M_RUN));
      chk("done",      32'(bus.done),      32'(m_state == M_DONE));
      if (prev_stall && bus.out_valid) begin
        chk("hold_spike", 32'(bus.spike_out), 32'(hold_spk));
        chk("hold_step",  32'(bus.step_idx),  32'(hold_step));
      end
      case (m_state)
        M_IDLE: begin
          if (bus.in_valid) begin
            for (int s = 0; s < T_STEPS; s++) begin
              exp_t e;
              e.step = SW'(s);
              for (int ch = 0; ch < N_CH; ch++) begin
                int iv;
                iv = intens_of(bus.in_data, ch);
                e.spk[ch] = (s == 0) ? 1'b0 :
                            (((((s + 1) * iv) >> VAL_W) - ((s * iv) >> VAL_W)) != 0);
              end
              q.push_back(e);
            end
            for (int ch = 0; ch < N_CH; ch++) begin
              cnt[ch]     = 0;
              exp_cnt[ch] = (T_STEPS * intens_of(bus.in_data, ch)) >> VAL_W;
            end
            prev_acc = last_acc;
            last_acc = cyc + 1;
            n_acc++;
            m_state = M_RUN;
          end
        end
        M_RUN: begin
          if (bus.out_ready) begin
            if (q.size() == 0) begin
              chk("queue_underrun", 32'd1, 32'd0);
              m_state = M_DONE;
            end else begin
              exp_t e;
              e = q.pop_front();
              chk("spike_out", 32'(bus.spike_out), 32'(e.spk));
              chk("step_idx",  32'(bus.step_idx),  32'(e.step));
              for (int ch = 0; ch < N_CH; ch++) cnt[ch] += int'(bus.spike_out[ch]);
              if (q.size() == 0) m_state = M_DONE;
            end
          end
        end
        default: begin
          done_cyc = cyc;
          n_done++;
          for (int ch = 0; ch < N_CH; ch++) chk("spike_count", 32'(cnt[ch]), 32'(exp_cnt[ch]));
          m_state = M_IDLE;
        end
      endcase
      prev_stall = bus.out_valid && !bus.out_ready;
      hold_spk   = bus.spike_out;
      hold_step  = bus.step_idx;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N_CH*VAL_W-1:0] d);
    int start;
    start = n_acc;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && n_acc == start; i++) tick();
    if (n_acc == start) chk("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit rnd_rdy);
    int start;
    start = n_done;
    for (int i = 0; i < 300 && n_done == start; i++) begin
      if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    if (n_done == start) chk("done_timeout", 32'd0, 32'd1);
    bus.out_ready = 1'b1;
  endtask

  task automatic wait_step(input int s);
    int i;
    for (i = 0; i < 50; i++) begin
      if (bus.out_valid && int'(bus.step_idx) == s) break;
      tick();
    end
    if (i == 50) chk("step_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_spike"},     32'(bus.spike_out), 32'd0);
    chk({tag, "_step"},      32'(bus.step_idx),  32'd0);
    chk({tag, "_done"},      32'(bus.done),      32'd0);
  endtask

  initial begin
    int a0;
    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rstn = 1'b1;
    chk_reset_outputs("reset");
    for (int i = 0; i < 10; i++) tick();
    chk_reset_outputs("idle");

    // Half intensity on channel 0: alternate spikes, 8 per frame.
    send(64'h00_00_00_00_00_00_00_80);
    wait_done(0);
    chk("latency_nominal", 32'(done_cyc - last_acc), 32'(T_STEPS));
    tick();
    chk("in_ready_after_done", 32'(bus.in_ready), 32'd1);

    // Mixed intensities 0, 64, 255, 1 on channels 0..3.
    send(64'h00_00_00_00_01_FF_40_00);
    wait_done(0);

    // Five-cycle stall while step 4 is presented.
    send(64'h00_00_00_00_00_00_00_80);
    wait_step(4);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    bus.out_ready = 1'b1;
    wait_done(0);
    chk("latency_stalled", 32'(done_cyc - last_acc), 32'(T_STEPS + 5));

    // Reset in the middle of a frame, then a fresh frame must start from a clear accumulator.
    send(64'h00_00_00_00_00_00_00_80);
    wait_step(7);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk_reset_outputs("midreset");
    send(64'h00_00_00_00_00_00_00_40);
    wait_done(0);

    // in_valid held high across two frames with in_data churning every cycle.
    a0 = n_acc;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 80 && n_acc < a0 + 2; i++) begin
      bus.in_data = {$urandom(), $urandom()};
      tick();
    end
    bus.in_valid = 1'b0;
    chk("two_frames_accepted", 32'(n_acc - a0), 32'd2);
    chk("frame_period", 32'(last_acc - prev_acc), 32'(T_STEPS + 2));
    wait_done(0);

    // Random intensities under random backpressure.
    for (int f = 0; f < 3; f++) begin
      send({$urandom(), $urandom()});
      wait_done(1);
    end

    for (int i = 0; i < 4; i++) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
